spi_xfer_arbiter: RTL

Transfer scheduler in front of the SPI master's shift/slave-select controller. It shares one SPI transfer engine between `NREQ` requesters using round-robin arbitration. It issues the one-cycle `send_data` start pulse, waits for the engine's `receive_data` completion pulse, and returns the received byte to the granted requester. It also enforces a guard gap between transfers and a watchdog timeout.

---
 rtl/spi_xfer_arbiter_pkg.sv | 5 +
 rtl/spi_xfer_arbiter_rr_arbiter.sv | 17 +
 rtl/spi_xfer_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_pkg.sv
// spi_pkg: shared FSM state encoding and guard-counter width for the SPI transfer arbiter.
package spi_pkg;
    localparam int GUARD_W = 4;
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_XFER, S_DONE, S_GAP} state_t;
endpackage

// File: rtl/spi_xfer_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin pick, searching upward from rr_ptr with wrap.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         gnt_next
);
    logic [2*NREQ-1:0] dreq, masked, low;
    // Doubling the request vector turns the wrap-around search into a plain lowest-set-bit pick.
    always_comb begin
        dreq     = {req, req};
        masked   = dreq & ~(((2*NREQ)'(1) << rr_ptr) - (2*NREQ)'(1));
        low      = masked & (~masked + (2*NREQ)'(1));
        gnt_next = low[NREQ-1:0] | low[2*NREQ-1:NREQ];
    end
endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin scheduler sharing one SPI transfer engine among NREQ requesters,
// with a guard gap between transfers and a transfer watchdog.
module spi_xfer_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int GUARD = 2,
    parameter int TMO_W = 16
) (
    input  logic                Pclk,
    input  logic                Preset,
    input  logic                enable,
    input  logic [TMO_W-1:0]    tmo_limit,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [DW-1:0]       rx_data,
    output logic                err,
    output logic                send_data,
    output logic [DW-1:0]       tx_data,
    output logic [NREQ-1:0]     ss_sel,
    input  logic                receive_data,
    input  logic [DW-1:0]       miso_data,
    output logic                busy
);
    localparam int PW = $clog2(NREQ);

    state_t             state, state_nx;
    logic [PW-1:0]      rr_ptr, g_idx, pick_idx;
    logic [NREQ-1:0]    gnt_next;
    logic [DW-1:0]      pick_data;
    logic [TMO_W-1:0]   wd_cnt;
    logic [GUARD_W-1:0] gap_cnt;
    logic               err_q, timeout;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .gnt_next (gnt_next)
    );

    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_next[i]) begin
                pick_idx  = PW'(i);
                pick_data = req_data[i*DW +: DW];
            end
    end

    assign timeout   = (tmo_limit != '0) && (wd_cnt == tmo_limit - TMO_W'(1));
    assign send_data = state == S_START;
    assign busy      = state != S_IDLE;
    assign done      = (state == S_DONE) ? gnt : '0;
    assign err       = err_q && state == S_DONE;
    assign ss_sel    = gnt;

    always_ff @(posedge Pclk) begin
        if (Preset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = (enable && |req) ? S_ARB : S_IDLE;
            S_ARB:   state_nx = |req ? S_START : S_IDLE;
            S_START: state_nx = S_XFER;
            S_XFER:  state_nx = (receive_data || timeout) ? S_DONE : S_XFER;
            S_DONE:  state_nx = (GUARD > 0) ? S_GAP : S_IDLE;
            S_GAP:   state_nx = (gap_cnt == GUARD_W'(GUARD - 1)) ? S_IDLE : S_GAP;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            gnt     <= '0;
            tx_data <= '0;
            rx_data <= '0;
            err_q   <= 1'b0;
            rr_ptr  <= '0;
            g_idx   <= '0;
            wd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == S_ARB && |req) begin
                gnt     <= gnt_next;
                tx_data <= pick_data;
                g_idx   <= pick_idx;
            end
            // Watchdog saturates so a long hang can never wrap back below the limit.
            if (state == S_START)
                wd_cnt <= '0;
            else if (state == S_XFER && wd_cnt != '1)
                wd_cnt <= wd_cnt + TMO_W'(1);
            if (state == S_XFER) begin
                if (receive_data) begin
                    rx_data <= miso_data;
                    err_q   <= 1'b0;
                end else if (timeout) begin
                    err_q   <= 1'b1;
                end
            end
            if (state == S_DONE) begin
                gnt     <= '0;
                rr_ptr  <= (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);
                gap_cnt <= '0;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt + GUARD_W'(1);
            end
        end
    end
endmodule
